// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    function automatic bit width_ok(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder built from two half adders; the only arithmetic
// in the serial adder, reused for every bit position.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_h0 (a, b, s0, c0);
    half_adder u_h1 (s0, ci, s, c1);

    assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder, building block of the shared full-adder cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic co
);

    assign s  = a ^ b;
    assign co = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: operands accepted on a valid/ready handshake,
// summed LSB-first through one full-adder cell, result held until taken.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("serial_add_ctrl: WIDTH out of range");
    end

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             cell_s;
    logic             cell_c;

    full_adder_bit u_fa (
        .a  (sh_a[0]),
        .b  (sh_b[0]),
        .ci (carry),
        .s  (cell_s),
        .co (cell_c)
    );

    // The unused encoding 2'b11 behaves as IDLE everywhere.
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);
    assign in_ready  = (state != RUN) && (state != DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    sum   <= {cell_s, sum[WIDTH-1:1]};
                    carry <= cell_c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        cout  <= cell_c;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    if (in_valid) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        sum   <= '0;
                        state <= RUN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=2.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic       rst_n8, iv8, rdy8, ov8, or8, busy8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       rst_n2, iv2, rdy2, ov2, or2, busy2, cout2;
    logic [1:0] a2, b2, sum2;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n8), .in_valid(iv8), .in_ready(rdy8),
        .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8),
        .sum(sum8), .cout(cout8), .busy(busy8)
    );

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n2), .in_valid(iv2), .in_ready(rdy2),
        .a(a2), .b(b2), .out_valid(ov2), .out_ready(or2),
        .sum(sum2), .cout(cout2), .busy(busy2)
    );

    typedef struct {
        logic [8:0] s;
        int         t;
    } e8_t;

    e8_t        q8[$];
    logic [2:0] q2[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor for the 8-bit instance: result, latency and busy span.
    initial begin : mon8
        int  busy_n = 0;
        logic prev_ov = 1'b0;
        e8_t e;
        forever begin
            @(negedge clk);
            if (!rst_n8) begin
                busy_n  = 0;
                prev_ov = 1'b0;
            end else begin
                if (busy8) busy_n++;
                if (ov8 && !prev_ov) begin
                    if (q8.size() == 0) begin
                        chk("spurious_valid8", 32'(q8.size()), 32'd1);
                    end else begin
                        chk("latency8", 32'(cyc - q8[0].t), 32'd8);
                        chk("busy_span8", 32'(busy_n), 32'd8);
                    end
                    busy_n = 0;
                end
                if (ov8 && or8) begin
                    if (q8.size() == 0) begin
                        chk("unexpected_out8", 32'(q8.size()), 32'd1);
                    end else begin
                        e = q8.pop_front();
                        chk("result8", 32'({cout8, sum8}), 32'(e.s));
                    end
                end
                prev_ov = ov8;
            end
        end
    end

    initial begin : mon2
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (rst_n2 && ov2 && or2) begin
                if (q2.size() == 0) begin
                    chk("unexpected_out2", 32'(q2.size()), 32'd1);
                end else begin
                    e = q2.pop_front();
                    chk("result2", 32'({cout2, sum2}), 32'(e));
                end
            end
        end
    end

    // Wait for IDLE; optional junk on in_valid/a/b while the DUT is busy.
    task automatic wait_idle8(input bit noise, input bit rnd_ready);
        int t = 0;
        while (!rdy8 && t < 300) begin
            if (noise) begin
                iv8 = 1'($urandom);
                a8  = 8'($urandom);
                b8  = 8'($urandom);
            end
            if (rnd_ready) or8 = 1'($urandom);
            @(posedge clk);
            #1;
            t++;
        end
        iv8 = 1'b0;
        if (t >= 300) chk("idle8_timeout", 32'(t), 32'd0);
    endtask

    task automatic send8(input logic [7:0] x, input logic [7:0] y);
        e8_t e;
        wait_idle8(1'b0, 1'b0);
        a8  = x;
        b8  = y;
        iv8 = 1'b1;
        @(posedge clk);
        #1;
        e.s = 9'(x) + 9'(y);
        e.t = cyc;
        q8.push_back(e);
        chk("accept8_busy", 32'(busy8), 32'd1);
        iv8 = 1'b0;
        a8  = 8'($urandom);
        b8  = 8'($urandom);
    endtask

    task automatic run8();
        int t;
        or8 = 1'b1;
        send8(8'h3C, 8'h5A);
        wait_idle8(1'b0, 1'b0);
        chk("idle_after_3c5a", 32'(busy8), 32'd0);

        send8(8'hFF, 8'h01);
        send8(8'hFF, 8'hFF);
        wait_idle8(1'b0, 1'b0);

        // Backpressure: result must hold while junk arrives on the inputs.
        or8 = 1'b0;
        send8(8'($urandom), 8'($urandom));
        t = 0;
        while (!ov8 && t < 50) begin
            iv8 = 1'($urandom);
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            @(posedge clk);
            #1;
            t++;
        end
        chk("bp_reach_done", 32'(ov8), 32'd1);
        for (int i = 0; i < 20; i++) begin
            iv8 = 1'($urandom);
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(ov8), 32'd1);
            chk("bp_ready_low", 32'(rdy8), 32'd0);
            if (q8.size() != 0)
                chk("bp_stable", 32'({cout8, sum8}), 32'(q8[0].s));
        end
        // in_valid stays high through the output handshake: no accept.
        iv8 = 1'b1;
        or8 = 1'b1;
        @(posedge clk);
        #1;
        chk("done_no_accept_busy", 32'(busy8), 32'd0);
        chk("done_no_accept_rdy", 32'(rdy8), 32'd1);
        iv8 = 1'b0;
        send8(8'h12, 8'h34);
        wait_idle8(1'b1, 1'b0);
        chk("idle_after_noise", 32'(busy8), 32'd0);

        // Asynchronous reset three cycles into RUN.
        send8(8'($urandom), 8'($urandom));
        repeat (3) @(posedge clk);
        #3;
        rst_n8 = 1'b0;
        #1;
        chk("rst_out_valid", 32'(ov8), 32'd0);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_sum", 32'(sum8), 32'd0);
        chk("rst_cout", 32'(cout8), 32'd0);
        chk("rst_in_ready", 32'(rdy8), 32'd1);
        q8.delete();
        @(posedge clk);
        #1;
        rst_n8 = 1'b1;
        send8(8'h10, 8'h20);
        wait_idle8(1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            send8(8'($urandom), 8'($urandom));
            wait_idle8(1'b1, 1'b1);
        end
        or8 = 1'b1;
        wait_idle8(1'b0, 1'b0);
    endtask

    task automatic run2();
        int prev = 0;
        int t;
        or2 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            t = 0;
            while (!rdy2 && t < 20) begin
                @(posedge clk);
                #1;
                t++;
            end
            if (t >= 20) chk("idle2_timeout", 32'(t), 32'd0);
            a2  = 2'(i >> 2);
            b2  = 2'(i);
            iv2 = 1'b1;
            @(posedge clk);
            #1;
            q2.push_back(3'(i >> 2) + 3'(i & 3));
            iv2 = 1'b0;
            if (i > 0) chk("ii2", 32'(cyc - prev), 32'd4);
            prev = cyc;
        end
        t = 0;
        while (!rdy2 && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n8 = 1'b0;
        rst_n2 = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b0;
        iv2 = 1'b0; a2 = '0; b2 = '0; or2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(rdy8), 32'd1);
        chk("reset_out_valid", 32'(ov8), 32'd0);
        chk("reset_busy", 32'(busy8), 32'd0);
        chk("reset_sum", 32'({cout8, sum8}), 32'd0);
        chk("reset_in_ready2", 32'(rdy2), 32'd1);
        rst_n8 = 1'b1;
        rst_n2 = 1'b1;
        @(posedge clk);
        #1;
        fork
            run8();
            run2();
        join
        repeat (2) @(posedge clk);
        #1;
        chk("drain8", 32'(q8.size()), 32'd0);
        chk("drain2", 32'(q2.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
